// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
// State encoding is visible on state_o, so the values are fixed.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } state_e;

  localparam logic [7:0] BCD_MILLI_MAX = 8'h99;
  localparam logic [7:0] BCD_SEC_MAX   = 8'h59;

  function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted rising edge of the debounced level.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Stability counter: any sample equal to the accepted level restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    press_d = level_d & ~level_q;
  end

  // Synchronizer, debounced level and press pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, 100 Hz count enable, run/pause/lap
// FSM and lap-freezable display register. STOPWATCH_AUTO_STOP_EN adds auto-stop at 59.99.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 100000000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [7:0] milli_in,
  input  logic [7:0] sec_in,
  output logic       count_en,
  output logic       count_clr,
  output logic [7:0] disp_milli,
  output logic [7:0] disp_sec,
  output logic [1:0] state_o,
  output logic       limit_hit
);

  localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic          ss_p;
  logic          lr_p;
  logic          counting;
  logic          tick;
  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          count_en_q;
  logic          count_en_d;
  logic          count_clr_q;
  logic          count_clr_d;
  logic [7:0]    disp_milli_q;
  logic [7:0]    disp_milli_d;
  logic [7:0]    disp_sec_q;
  logic [7:0]    disp_sec_d;
`ifdef STOPWATCH_AUTO_STOP_EN
  logic          at_max;
  logic          limit_q;
  logic          limit_d;
`endif

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_ss (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_ss),
    .press   (ss_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_lr (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_lr),
    .press   (lr_p)
  );

  // Prescaler, FSM next state, strobes and display next value.
  always_comb begin
    counting    = (state_q == RUNNING) || (state_q == LAP);
    tick        = counting && (presc_q == PRESC_LAST);
    presc_d     = '0;
    state_d     = state_q;
    count_en_d  = tick;
    count_clr_d = 1'b0;
    if (counting) begin
      presc_d = tick ? '0 : (presc_q + PRESC_ONE);
    end else begin
      presc_d = '0;
    end

    // ss_p is checked first everywhere so it wins over a simultaneous lr_p.
    case (state_q)
      IDLE: begin
        if (ss_p) begin
          state_d = RUNNING;
        end else if (lr_p) begin
          count_clr_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUNNING: begin
        if (ss_p) begin
          state_d = PAUSED;
        end else if (lr_p) begin
          state_d = LAP;
        end else begin
          state_d = RUNNING;
        end
      end
      LAP: begin
        if (ss_p) begin
          state_d = PAUSED;
        end else if (lr_p) begin
          state_d = RUNNING;
        end else begin
          state_d = LAP;
        end
      end
      PAUSED: begin
        if (ss_p) begin
          state_d = RUNNING;
        end else if (lr_p) begin
          state_d     = IDLE;
          count_clr_d = 1'b1;
        end else begin
          state_d = PAUSED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef STOPWATCH_AUTO_STOP_EN
    at_max  = (milli_in == BCD_MILLI_MAX) && (sec_in == BCD_SEC_MAX);
    limit_d = limit_q;
    if (ss_p || lr_p) begin
      limit_d = 1'b0;
    end else begin
      limit_d = limit_q;
    end
    // Suppress the tick that would wrap 59.99 and park in PAUSED.
    if (tick && at_max) begin
      count_en_d = 1'b0;
      state_d    = PAUSED;
      limit_d    = 1'b1;
    end else begin
      count_en_d = tick;
    end
`endif

    // The display holds only while staying in LAP; entering LAP captures live.
    if ((state_q == LAP) && (state_d == LAP)) begin
      disp_milli_d = disp_milli_q;
      disp_sec_d   = disp_sec_q;
    end else begin
      disp_milli_d = milli_in;
      disp_sec_d   = sec_in;
    end
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      count_en_q   <= 1'b0;
      count_clr_q  <= 1'b0;
      disp_milli_q <= 8'h00;
      disp_sec_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      count_en_q   <= count_en_d;
      count_clr_q  <= count_clr_d;
      disp_milli_q <= disp_milli_d;
      disp_sec_q   <= disp_sec_d;
    end
  end

`ifdef STOPWATCH_AUTO_STOP_EN
  // Sticky auto-stop indicator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      limit_q <= 1'b0;
    end else begin
      limit_q <= limit_d;
    end
  end

  assign limit_hit = limit_q;
`else
  assign limit_hit = 1'b0;
`endif

  assign count_en   = count_en_q;
  assign count_clr  = count_clr_q;
  assign disp_milli = disp_milli_q;
  assign disp_sec   = disp_sec_q;
  assign state_o    = state_q;

endmodule
